pe_mac_pipe: RTL and testbench

//   Parametrised, pipelined successor of the single-cycle parallel PE. It is a

---
 rtl/pe_mac_pipe.sv | 177 +++++++++++++++++
 tb/tb_pe_mac_pipe.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_pipe.sv
// pe_mac_pipe: LANES-wide signed dot-product engine (multiply, adder tree, accumulate)
// with valid/ready on both sides. Define PE_SAT_EN for saturating narrowing and accumulation.
module pe_mac_pipe #(
  parameter int LANES = 32,
  parameter int DW    = 16,
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LANES*DW-1:0] neuron,
  input  logic [LANES*DW-1:0] weight,
  input  logic [1:0]          ctl,
  input  logic                vld_i,
  output logic                rdy_o,
  output logic [ACC_W-1:0]    result,
  output logic [CNT_W-1:0]    beats,
  output logic                vld_o,
  input  logic                rdy_i
);
  localparam int PW    = 2 * DW;
  localparam int SUM_W = PW + $clog2(LANES);

  typedef enum logic [1:0] {
    CTL_FIRST  = 2'b00,
    CTL_MID    = 2'b01,
    CTL_LAST   = 2'b10,
    CTL_SINGLE = 2'b11
  } ctl_e;

  logic             stall;
  logic             adv;
  logic [PW-1:0]    prod_d [LANES];
  logic [PW-1:0]    prod_q [LANES];
  logic             s1_vld_q;
  ctl_e             s1_ctl_q;
  logic [SUM_W-1:0] sum_full;
  logic [SUM_W-1:0] sum_q;
  logic             s2_vld_q;
  ctl_e             s2_ctl_q;
  logic [ACC_W-1:0] sum_narrow;
  logic [ACC_W-1:0] psum_q, psum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [ACC_W-1:0] result_q, result_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic             vld_o_q, vld_o_d;

  // A result waiting on a busy consumer freezes the whole pipe, input side included.
  assign stall = vld_o_q & ~rdy_i;
  assign adv   = ~stall;
  assign rdy_o = adv;

  // Sign-extending both operands to PW makes the low PW bits of the unsigned product exact.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [PW-1:0] n_ext, w_ext;
    assign n_ext      = {{DW{neuron[gi*DW+DW-1]}}, neuron[gi*DW +: DW]};
    assign w_ext      = {{DW{weight[gi*DW+DW-1]}}, weight[gi*DW +: DW]};
    assign prod_d[gi] = n_ext * w_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
      s1_vld_q <= 1'b0;
      s1_ctl_q <= CTL_FIRST;
    end else if (adv) begin
      for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
      s1_vld_q <= vld_i;
      s1_ctl_q <= ctl_e'(ctl);
    end
  end

  always_comb begin
    sum_full = '0;
    for (int i = 0; i < LANES; i++)
      sum_full = sum_full + {{(SUM_W-PW){prod_q[i][PW-1]}}, prod_q[i]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q    <= '0;
      s2_vld_q <= 1'b0;
      s2_ctl_q <= CTL_FIRST;
    end else if (adv) begin
      sum_q    <= sum_full;
      s2_vld_q <= s1_vld_q;
      s2_ctl_q <= s1_ctl_q;
    end
  end

`ifdef PE_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Fits in ACC_W only when every bit from the ACC_W-1 sign position upward agrees.
  logic [SUM_W-ACC_W:0] sum_top;
  assign sum_top = sum_q[SUM_W-1:ACC_W-1];

  always_comb begin
    if (sum_top == '0 || sum_top == '1) sum_narrow = sum_q[ACC_W-1:0];
    else if (sum_q[SUM_W-1])             sum_narrow = ACC_MIN;
    else                                 sum_narrow = ACC_MAX;
  end

  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
    logic [ACC_W:0] t;
    t = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (t[ACC_W] != t[ACC_W-1]) return t[ACC_W] ? ACC_MIN : ACC_MAX;
    return t[ACC_W-1:0];
  endfunction
`else
  logic unused_sum_bits;
  assign unused_sum_bits = ^sum_q;
  assign sum_narrow      = sum_q[ACC_W-1:0];

  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
    return a + b;
  endfunction
`endif

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    psum_d   = psum_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    beats_d  = beats_q;
    vld_o_d  = vld_o_q & ~rdy_i;
    if (s2_vld_q) begin
      case (s2_ctl_q)
        CTL_FIRST: begin
          psum_d = sum_narrow;
          cnt_d  = CNT_W'(1);
        end
        CTL_MID: begin
          psum_d = acc_add(psum_q, sum_narrow);
          cnt_d  = cnt_inc;
        end
        CTL_LAST: begin
          result_d = acc_add(psum_q, sum_narrow);
          beats_d  = cnt_inc;
          vld_o_d  = 1'b1;
          psum_d   = '0;
          cnt_d    = '0;
        end
        default: begin
          result_d = sum_narrow;
          beats_d  = CNT_W'(1);
          vld_o_d  = 1'b1;
          psum_d   = '0;
          cnt_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psum_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      beats_q  <= '0;
      vld_o_q  <= 1'b0;
    end else if (adv) begin
      psum_q   <= psum_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      beats_q  <= beats_d;
      vld_o_q  <= vld_o_d;
    end
  end

  assign result = result_q;
  assign beats  = beats_q;
  assign vld_o  = vld_o_q;

endmodule

// File: tb/tb_pe_mac_pipe.sv
// tb_pe_mac_pipe: scoreboard bench for pe_mac_pipe; expected results are queued as beats
// are accepted and compared in order against results taken at the output handshake.
module tb_pe_mac_pipe;
  localparam int LANES = 32;
  localparam int DW    = 16;
  localparam int ACC_W = 32;
  localparam int CNT_W = 8;
  localparam int VW    = LANES * DW;
  localparam int OW    = ACC_W + CNT_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [VW-1:0]    neuron, weight;
  logic [1:0]       ctl;
  logic             vld_i, rdy_o, vld_o, rdy_i;
  logic [ACC_W-1:0] result;
  logic [CNT_W-1:0] beats;

  int errors = 0;
  int checks = 0;
  logic [OW-1:0]    exp_q[$];
  logic [OW-1:0]    obs_q[$];
  logic [ACC_W-1:0] m_psum = '0;
  int               m_cnt = 0;

  always #5 clk = ~clk;

  pe_mac_pipe #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .neuron(neuron), .weight(weight), .ctl(ctl),
    .vld_i(vld_i), .rdy_o(rdy_o), .result(result), .beats(beats),
    .vld_o(vld_o), .rdy_i(rdy_i)
  );

  function automatic logic [VW-1:0] fill(input logic [DW-1:0] v);
    logic [VW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic longint dot(input logic [VW-1:0] n, input logic [VW-1:0] w);
    longint s;
    logic signed [DW-1:0] a, b;
    s = 0;
    for (int i = 0; i < LANES; i++) begin
      a = n[i*DW +: DW];
      b = w[i*DW +: DW];
      s += longint'(a) * longint'(b);
    end
    return s;
  endfunction

  function automatic logic [ACC_W-1:0] narrow(input longint s);
`ifdef PE_SAT_EN
    if (s > 64'sd2147483647)  return 32'h7FFFFFFF;
    if (s < -64'sd2147483648) return 32'h80000000;
`endif
    return s[ACC_W-1:0];
  endfunction

  function automatic logic [ACC_W-1:0] madd(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
`ifdef PE_SAT_EN
    return narrow(longint'($signed(a)) + longint'($signed(b)));
`else
    return a + b;
`endif
  endfunction

  task automatic model_accept(input logic [1:0] c, input logic [VW-1:0] n, input logic [VW-1:0] w);
    logic [ACC_W-1:0] s;
    int nc;
    s  = narrow(dot(n, w));
    nc = (m_cnt < 255) ? m_cnt + 1 : 255;
    case (c)
      2'b00: begin m_psum = s; m_cnt = 1; end
      2'b01: begin m_psum = madd(m_psum, s); m_cnt = nc; end
      2'b10: begin exp_q.push_back({madd(m_psum, s), CNT_W'(nc)}); m_psum = '0; m_cnt = 0; end
      default: begin exp_q.push_back({s, CNT_W'(1)}); m_psum = '0; m_cnt = 0; end
    endcase
  endtask

  // One clock: apply inputs, feed the model on acceptance, log a taken result.
  task automatic tick(input logic v, input logic [1:0] c, input logic [VW-1:0] n,
                      input logic [VW-1:0] w, input logic r, output logic acc);
    vld_i = v; ctl = c; neuron = n; weight = w; rdy_i = r;
    #1;
    acc = v && rdy_o;
    if (acc) model_accept(c, n, w);
    if (vld_o && rdy_i) obs_q.push_back({result, beats});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    logic a;
    repeat (n) tick(1'b0, 2'b00, '0, '0, 1'b1, a);
  endtask

  task automatic test_reset();
    checks++;
    if (result !== '0 || beats !== '0 || vld_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: result=%h beats=%0d vld_o=%b, expected 0 0 0", result, beats, vld_o);
    end
    rdy_i = 1'b1; #1;
    checks++;
    if (rdy_o !== 1'b1) begin errors++; $display("FAIL reset_rdy: rdy_o=%b, expected 1", rdy_o); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (vld_o !== 1'b0 || rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: vld_o=%b rdy_o=%b, expected 0 1", vld_o, rdy_o);
    end
  endtask

  task automatic test_single();
    logic a;
    logic [OW-1:0] o, e;
    tick(1'b1, 2'b11, fill(16'd1), fill(16'd2), 1'b1, a);
    checks++;
    if (vld_o !== 1'b0) begin errors++; $display("FAIL single_t1: vld_o=%b, expected 0", vld_o); end
    idle(1);
    checks++;
    if (vld_o !== 1'b0) begin errors++; $display("FAIL single_t2: vld_o=%b, expected 0", vld_o); end
    idle(1);
    checks++;
    if (vld_o !== 1'b1 || result !== 32'd64 || beats !== 8'd1) begin
      errors++;
      $display("FAIL single_t3: vld_o=%b result=%0d beats=%0d, expected 1 64 1", vld_o, result, beats);
    end
    idle(1);
    checks++;
    if (vld_o !== 1'b0) begin errors++; $display("FAIL single_t4: vld_o=%b, expected 0", vld_o); end
    idle(4);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (exp_q.size() > 0) e = exp_q.pop_front(); else e = {OW{1'bx}};
      checks++;
      if (o !== e) begin errors++; $display("FAIL sb_single: result=%h beats=%0d, expected result=%h beats=%0d", o[OW-1:CNT_W], o[CNT_W-1:0], e[OW-1:CNT_W], e[CNT_W-1:0]); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_single_lost: %0d results missing, expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_back_to_back();
    logic a;
    logic [OW-1:0] o, e;
    tick(1'b1, 2'b00, fill(16'd1), fill(16'd2), 1'b1, a);
    tick(1'b1, 2'b01, fill(16'd1), fill(16'd2), 1'b1, a);
    tick(1'b1, 2'b10, fill(16'd1), fill(16'd2), 1'b1, a);
    checks++;
    if (vld_o !== 1'b0) begin errors++; $display("FAIL b2b_first: vld_o=%b, expected 0", vld_o); end
    idle(1);
    checks++;
    if (vld_o !== 1'b0) begin errors++; $display("FAIL b2b_mid: vld_o=%b, expected 0", vld_o); end
    idle(1);
    checks++;
    if (vld_o !== 1'b1 || result !== 32'd192 || beats !== 8'd3) begin
      errors++;
      $display("FAIL b2b_last: vld_o=%b result=%0d beats=%0d, expected 1 192 3", vld_o, result, beats);
    end
    idle(5);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (exp_q.size() > 0) e = exp_q.pop_front(); else e = {OW{1'bx}};
      checks++;
      if (o !== e) begin errors++; $display("FAIL sb_b2b: result=%h beats=%0d, expected result=%h beats=%0d", o[OW-1:CNT_W], o[CNT_W-1:0], e[OW-1:CNT_W], e[CNT_W-1:0]); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_b2b_lost: %0d results missing, expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  // Directed SINGLE with a fixed expected result, also cross-checked against the model.
  task automatic test_const(input string tag, input logic [DW-1:0] nv, input logic [DW-1:0] wv,
                            input logic [ACC_W-1:0] want);
    logic a;
    logic [OW-1:0] o, e;
    tick(1'b1, 2'b11, fill(nv), fill(wv), 1'b1, a);
    idle(6);
    checks++;
    if (obs_q.size() == 0 || obs_q[0][OW-1:CNT_W] !== want) begin
      errors++;
      $display("FAIL %s: result=%h (outputs seen %0d), expected %h", tag,
               (obs_q.size() > 0) ? obs_q[0][OW-1:CNT_W] : 32'hx, obs_q.size(), want);
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (exp_q.size() > 0) e = exp_q.pop_front(); else e = {OW{1'bx}};
      checks++;
      if (o !== e) begin errors++; $display("FAIL sb_%s: result=%h beats=%0d, expected result=%h beats=%0d", tag, o[OW-1:CNT_W], o[CNT_W-1:0], e[OW-1:CNT_W], e[CNT_W-1:0]); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_%s_lost: %0d results missing, expected 0", tag, exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_stall();
    logic a;
    logic [1:0] c;
    logic [OW-1:0] o, e;
    logic [ACC_W-1:0] held_r;
    logic [CNT_W-1:0] held_b;
    int sent = 0;
    int stall_left = -1;
    int cyc = 0;
    held_r = '0; held_b = '0;
    while (sent < 8 && cyc < 100) begin
      c = (sent == 0) ? 2'b00 : (sent == 1) ? 2'b01 : (sent == 2) ? 2'b10 : 2'b11;
      if (stall_left < 0 && vld_o === 1'b1) begin
        stall_left = 5; held_r = result; held_b = beats;
      end
      if (stall_left > 0) begin
        rdy_i = 1'b0; vld_i = 1'b1; #1;
        checks++;
        if (rdy_o !== 1'b0) begin errors++; $display("FAIL stall_rdy: rdy_o=%b, expected 0", rdy_o); end
        checks++;
        if (vld_o !== 1'b1 || result !== held_r || beats !== held_b) begin
          errors++;
          $display("FAIL stall_hold: vld_o=%b result=%h beats=%0d, expected 1 %h %0d", vld_o, result, beats, held_r, held_b);
        end
        stall_left--;
        tick(1'b1, c, fill(DW'(sent + 1)), fill(16'd2), 1'b0, a);
      end else begin
        tick(1'b1, c, fill(DW'(sent + 1)), fill(16'd2), 1'b1, a);
      end
      if (a) sent++;
      cyc++;
    end
    checks++;
    if (sent != 8 || stall_left != 0) begin errors++; $display("FAIL stall_progress: sent=%0d stalls_left=%0d, expected 8 0", sent, stall_left); end
    idle(8);
    checks++;
    if (obs_q.size() != 6) begin errors++; $display("FAIL stall_count: %0d results, expected 6", obs_q.size()); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (exp_q.size() > 0) e = exp_q.pop_front(); else e = {OW{1'bx}};
      checks++;
      if (o !== e) begin errors++; $display("FAIL sb_stall: result=%h beats=%0d, expected result=%h beats=%0d", o[OW-1:CNT_W], o[CNT_W-1:0], e[OW-1:CNT_W], e[CNT_W-1:0]); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_stall_lost: %0d results missing, expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_mid();
    logic a;
    logic [OW-1:0] o, e;
    tick(1'b1, 2'b11, fill(16'd1), fill(16'd2), 1'b1, a);
    tick(1'b1, 2'b00, fill(16'd1), fill(16'd2), 1'b1, a);
    tick(1'b1, 2'b01, fill(16'd1), fill(16'd2), 1'b1, a);
    vld_i = 1'b0; rdy_i = 1'b0; #1;
    checks++;
    if (vld_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre: vld_o=%b, expected 1", vld_o); end
    rst_n = 1'b0; #1;
    checks++;
    if (vld_o !== 1'b0 || result !== '0 || beats !== '0 || rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_clear: vld_o=%b result=%h beats=%0d rdy_o=%b, expected 0 0 0 1", vld_o, result, beats, rdy_o);
    end
    exp_q.delete(); obs_q.delete(); m_psum = '0; m_cnt = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tick(1'b1, 2'b10, fill(16'd1), fill(16'd2), 1'b1, a);
    idle(6);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {32'd64, 8'd1}) begin
      errors++;
      $display("FAIL rstmid_last: %0d results, first=%h, expected 1 result 00000040_01", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : {OW{1'bx}});
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (exp_q.size() > 0) e = exp_q.pop_front(); else e = {OW{1'bx}};
      checks++;
      if (o !== e) begin errors++; $display("FAIL sb_rstmid: result=%h beats=%0d, expected result=%h beats=%0d", o[OW-1:CNT_W], o[CNT_W-1:0], e[OW-1:CNT_W], e[CNT_W-1:0]); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_rstmid_lost: %0d results missing, expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_cnt_sat();
    logic a;
    logic [OW-1:0] o, e;
    tick(1'b1, 2'b00, fill(16'd1), fill(16'd1), 1'b1, a);
    repeat (299) tick(1'b1, 2'b01, fill(16'd1), fill(16'd1), 1'b1, a);
    tick(1'b1, 2'b10, fill(16'd1), fill(16'd1), 1'b1, a);
    idle(6);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {32'd9632, 8'd255}) begin
      errors++;
      $display("FAIL cnt_sat: %0d results, first=%h, expected 1 result 000025a0_ff", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : {OW{1'bx}});
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (exp_q.size() > 0) e = exp_q.pop_front(); else e = {OW{1'bx}};
      checks++;
      if (o !== e) begin errors++; $display("FAIL sb_cntsat: result=%h beats=%0d, expected result=%h beats=%0d", o[OW-1:CNT_W], o[CNT_W-1:0], e[OW-1:CNT_W], e[CNT_W-1:0]); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_cntsat_lost: %0d results missing, expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_random();
    logic a;
    logic [VW-1:0] n, w;
    logic [OW-1:0] o, e;
    for (int k = 0; k < 120; k++) begin
      for (int l = 0; l < LANES; l++) begin
        n[l*DW +: DW] = DW'($urandom);
        w[l*DW +: DW] = DW'($urandom);
      end
      tick(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), n, w, ($urandom_range(0, 3) != 0), a);
    end
    idle(8);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (exp_q.size() > 0) e = exp_q.pop_front(); else e = {OW{1'bx}};
      checks++;
      if (o !== e) begin errors++; $display("FAIL sb_rand: result=%h beats=%0d, expected result=%h beats=%0d", o[OW-1:CNT_W], o[CNT_W-1:0], e[OW-1:CNT_W], e[CNT_W-1:0]); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_rand_lost: %0d results missing, expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    rst_n = 1'b0; vld_i = 1'b0; rdy_i = 1'b1; ctl = 2'b00; neuron = '0; weight = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_const("neg", 16'hFFFF, 16'd3, 32'hFFFFFFA0);
`ifdef PE_SAT_EN
    test_const("ovf", 16'h7FFF, 16'h7FFF, 32'h7FFFFFFF);
`else
    test_const("ovf", 16'h7FFF, 16'h7FFF, 32'hFFE00020);
`endif
    test_stall();
    test_reset_mid();
    test_cnt_sat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
